id_ex_stage: RTL and testbench

//  ID/EX pipeline register fed by the opcode control decoder and the register file.

---
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush bubbles and EX hold.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm         XLEN-wide operands from ID / register file
//   id_rs1, id_rs2, id_rd       register indices
//   id_rs1_ren, id_rs2_ren      ID instruction reads rs1 / rs2
//   id_funct3, id_funct7b5      instruction function fields
//   id_branch, id_reg_wena,
//   id_mem2reg, id_mem_rena,
//   id_mem_wena, id_alusrc,
//   id_aluop, id_jump           decoder control outputs
//   ex_flush                    EX redirects PC; kill the ID instruction
//   ex_hold                     EX multi-cycle op busy; freeze ID/EX
//   ex_*                        registered copies of every id_* input
//   stall                       combinational; hold PC and IF/ID this cycle
//   perf_stall_cnt,
//   perf_flush_cnt              stall / flush cycle counters (only with ID_EX_PERF_EN)
//
// Optional feature: define ID_EX_PERF_EN to add the two performance counters.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_rs1_ren,
    input  logic               id_rs2_ren,
    input  logic [2:0]         id_funct3,
    input  logic               id_funct7b5,
    input  logic               id_branch,
    input  logic               id_reg_wena,
    input  logic               id_mem2reg,
    input  logic               id_mem_rena,
    input  logic               id_mem_wena,
    input  logic               id_alusrc,
    input  logic [2:0]         id_aluop,
    input  logic [1:0]         id_jump,
    input  logic               ex_flush,
    input  logic               ex_hold,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_rs1_ren,
    output logic               ex_rs2_ren,
    output logic [2:0]         ex_funct3,
    output logic               ex_funct7b5,
    output logic               ex_branch,
    output logic               ex_reg_wena,
    output logic               ex_mem2reg,
    output logic               ex_mem_rena,
    output logic               ex_mem_wena,
    output logic               ex_alusrc,
    output logic [2:0]         ex_aluop,
    output logic [1:0]         ex_jump,
`ifdef ID_EX_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               stall
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic bubble;
    logic capture;

    // A load in EX whose destination is a live source of the ID instruction
    // cannot forward in time, so ID must wait one cycle behind a bubble.
    assign rs1_hit  = id_rs1_ren && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_ren && (id_rs2 == ex_rd);
    assign load_use = ex_valid && ex_mem_rena && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);

    assign stall = !ex_flush && (ex_hold || load_use);

    // Flush beats hold and load-use; hold beats load-use.
    assign bubble  = ex_flush || (!ex_hold && load_use);
    assign capture = !ex_flush && !ex_hold && !load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_ren  <= 1'b0;
            ex_rs2_ren  <= 1'b0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_branch   <= 1'b0;
            ex_reg_wena <= 1'b0;
            ex_mem2reg  <= 1'b0;
            ex_mem_rena <= 1'b0;
            ex_mem_wena <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= '0;
            ex_jump     <= '0;
        end else if (bubble) begin
            // Only the state-changing controls are killed; data fields hold.
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_reg_wena <= 1'b0;
            ex_mem2reg  <= 1'b0;
            ex_mem_rena <= 1'b0;
            ex_mem_wena <= 1'b0;
            ex_jump     <= '0;
        end else if (capture) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_ren  <= id_rs1_ren;
            ex_rs2_ren  <= id_rs2_ren;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
            // An invalid ID slot becomes a bubble whatever the decoder drives.
            ex_branch   <= id_valid && id_branch;
            ex_reg_wena <= id_valid && id_reg_wena;
            ex_mem2reg  <= id_valid && id_mem2reg;
            ex_mem_rena <= id_valid && id_mem_rena;
            ex_mem_wena <= id_valid && id_mem_wena;
            ex_alusrc   <= id_valid && id_alusrc;
            ex_aluop    <= id_valid ? id_aluop : 3'b000;
            ex_jump     <= id_valid ? id_jump : 2'b00;
        end
    end

`ifdef ID_EX_PERF_EN
    // Free-running counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'd0, stall};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, ex_flush};
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_ren, id_rs2_ren;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_branch, id_reg_wena, id_mem2reg, id_mem_rena, id_mem_wena, id_alusrc;
    logic [2:0]  id_aluop;
    logic [1:0]  id_jump;
    logic        ex_flush, ex_hold;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_rs1_ren, ex_rs2_ren;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_branch, ex_reg_wena, ex_mem2reg, ex_mem_rena, ex_mem_wena, ex_alusrc;
    logic [2:0]  ex_aluop;
    logic [1:0]  ex_jump;
    logic        stall;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_branch(id_branch), .id_reg_wena(id_reg_wena), .id_mem2reg(id_mem2reg),
        .id_mem_rena(id_mem_rena), .id_mem_wena(id_mem_wena), .id_alusrc(id_alusrc),
        .id_aluop(id_aluop), .id_jump(id_jump),
        .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_ren(ex_rs1_ren), .ex_rs2_ren(ex_rs2_ren),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_branch(ex_branch), .ex_reg_wena(ex_reg_wena), .ex_mem2reg(ex_mem2reg),
        .ex_mem_rena(ex_mem_rena), .ex_mem_wena(ex_mem_wena), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_jump(ex_jump),
`ifdef ID_EX_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .stall(stall)
    );

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_ren = 0; id_rs2_ren = 0;
        id_funct3 = 0; id_funct7b5 = 0; id_branch = 0; id_reg_wena = 0;
        id_mem2reg = 0; id_mem_rena = 0; id_mem_wena = 0; id_alusrc = 0;
        id_aluop = 0; id_jump = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        set_idle();
        id_valid = 1; id_pc = 32'h40; id_rs1 = 5'd1; id_rs1_ren = 1; id_rd = rd;
        id_imm = 32'h8; id_funct3 = 3'b010; id_reg_wena = 1; id_mem2reg = 1;
        id_mem_rena = 1; id_alusrc = 1;
    endtask

    task automatic set_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic rs2_ren, input logic [4:0] rd);
        set_idle();
        id_valid = 1; id_pc = 32'h44; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_ren = 1; id_rs2_ren = rs2_ren; id_rd = rd; id_reg_wena = 1; id_aluop = 3'b010;
    endtask

    task automatic test_reset();
        rst = 1; ex_flush = 0; ex_hold = 0;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_imm = $urandom; id_rd = 5'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
            id_branch = 1; id_reg_wena = 1; id_mem_rena = 1; id_mem_wena = 1; id_jump = 2'b01;
            id_aluop = 3'($urandom); ex_flush = 1'($urandom);
            step();
        end
        ex_flush = 0;
        checks++;
        if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_rs1_ren, ex_rs2_ren, ex_funct3, ex_funct7b5, ex_branch, ex_reg_wena,
             ex_mem2reg, ex_mem_rena, ex_mem_wena, ex_alusrc, ex_aluop, ex_jump} !== '0) begin
            errors++; $display("FAIL reset_ex: ex_valid=%b ex_pc=%h ex_rd=%0d ex_jump=%b required all zero", ex_valid, ex_pc, ex_rd, ex_jump);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 0;
        set_idle();
    endtask

    task automatic test_pass_through();
        set_idle();
        id_valid = 1; id_pc = 32'h100; id_aluop = 3'b010; id_rd = 5'd5; id_imm = 32'hFFFF_FFF0;
        step();
        checks++;
        if (ex_pc !== 32'h100 || ex_aluop !== 3'b010 || ex_rd !== 5'd5 || ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFF0) begin
            errors++; $display("FAIL pass_through: pc=%h aluop=%b rd=%0d valid=%b imm=%h want 100/010/5/1/fffffff0", ex_pc, ex_aluop, ex_rd, ex_valid, ex_imm);
        end
    endtask

    task automatic test_load_use();
        set_load(5'd5); step();
        set_add(5'd3, 5'd5, 1'b1, 5'd6); #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_mem_rena !== 1'b0 || ex_reg_wena !== 1'b0) begin
            errors++; $display("FAIL load_use_bubble: valid=%b mem_rena=%b reg_wena=%b want 0/0/0", ex_valid, ex_mem_rena, ex_reg_wena);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_clear: stall=%b want 0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h44 || ex_reg_wena !== 1'b1) begin
            errors++; $display("FAIL load_use_capture: valid=%b rd=%0d pc=%h reg_wena=%b want 1/6/44/1", ex_valid, ex_rd, ex_pc, ex_reg_wena);
        end
    endtask

    task automatic test_no_hazard();
        set_load(5'd0); step();
        set_add(5'd3, 5'd0, 1'b1, 5'd6); #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL no_hazard_rd0: stall=%b want 0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL no_hazard_rd0_capture: valid=%b rd=%0d want 1/6", ex_valid, ex_rd); end
        set_load(5'd5); step();
        set_add(5'd3, 5'd5, 1'b0, 5'd7); #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL no_hazard_noren: stall=%b want 0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin errors++; $display("FAIL no_hazard_noren_capture: valid=%b rd=%0d want 1/7", ex_valid, ex_rd); end
    endtask

    task automatic test_flush();
        set_load(5'd5); step();
        set_add(5'd3, 5'd5, 1'b1, 5'd6);
        id_mem_wena = 1; id_jump = 2'b10; ex_flush = 1; ex_hold = 1; #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: stall=%b want 0", stall); end
        step();
        ex_flush = 0; ex_hold = 0;
        checks++;
        if (ex_valid !== 1'b0 || ex_mem_wena !== 1'b0 || ex_jump !== 2'b00 || ex_mem_rena !== 1'b0 || ex_reg_wena !== 1'b0) begin
            errors++; $display("FAIL flush_bubble: valid=%b mem_wena=%b jump=%b mem_rena=%b reg_wena=%b want all 0", ex_valid, ex_mem_wena, ex_jump, ex_mem_rena, ex_reg_wena);
        end
        set_idle();
        step();
    endtask

    task automatic test_bubble_invalid();
        set_idle();
        id_pc = 32'h55; id_branch = 1; id_jump = 2'b01; id_mem_wena = 1; id_reg_wena = 1; id_mem_rena = 1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_branch !== 1'b0 || ex_jump !== 2'b00 || ex_mem_wena !== 1'b0 || ex_reg_wena !== 1'b0 || ex_mem_rena !== 1'b0) begin
            errors++; $display("FAIL invalid_bubble: valid=%b branch=%b jump=%b mem_wena=%b reg_wena=%b mem_rena=%b want all 0", ex_valid, ex_branch, ex_jump, ex_mem_wena, ex_reg_wena, ex_mem_rena);
        end
    endtask

    task automatic test_back_to_back();
        set_load(5'd9); step();
        set_add(5'd9, 5'd9, 1'b1, 5'd10); #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL two_src_stall: stall=%b want 1", stall); end
        step();
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL two_src_one_bubble: stall=%b valid=%b want 0/0", stall, ex_valid); end
        step();
        set_idle(); id_valid = 1; id_pc = 32'h304; id_rd = 5'd11;
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin errors++; $display("FAIL two_src_capture: valid=%b rd=%0d want 1/10", ex_valid, ex_rd); end
        step();
        checks++;
        if (ex_pc !== 32'h304 || ex_rd !== 5'd11) begin errors++; $display("FAIL back_to_back: pc=%h rd=%0d want 304/11", ex_pc, ex_rd); end
    endtask

    task automatic test_hold();
        rst = 1; set_idle(); step(); rst = 0;
        id_valid = 1; id_pc = 32'h200; id_rd = 5'd7; id_aluop = 3'b011; id_reg_wena = 1;
        step();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h300 + 32'(4 * i); id_rd = 5'd20 + 5'(i); #1;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: stall=%b want 1", i, stall); end
            step();
            checks++;
            if (ex_pc !== 32'h200 || ex_rd !== 5'd7 || ex_aluop !== 3'b011 || ex_valid !== 1'b1) begin
                errors++; $display("FAIL hold_freeze[%0d]: pc=%h rd=%0d aluop=%b valid=%b want 200/7/011/1", i, ex_pc, ex_rd, ex_aluop, ex_valid);
            end
        end
        ex_hold = 0;
`ifdef ID_EX_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_cnt: stall_cnt=%0d flush_cnt=%0d want 3/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL hold_release: stall=%b want 0", stall); end
        step();
        checks++;
        if (ex_pc !== 32'h308 || ex_rd !== 5'd22) begin errors++; $display("FAIL hold_release_capture: pc=%h rd=%0d want 308/22", ex_pc, ex_rd); end
    endtask

    task automatic test_reset_mid_stall();
        set_load(5'd4); step();
        set_add(5'd4, 5'd0, 1'b0, 5'd8); #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_pre: stall=%b want 1", stall); end
        rst = 1;
        step();
        rst = 0; #1;
        checks++;
        if (ex_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: valid=%b stall=%b want 0/0", ex_valid, stall); end
        ex_hold = 1; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_hold: stall=%b want 1", stall); end
        ex_hold = 0;
        set_idle();
        step();
    endtask

    initial begin
        rst = 1; ex_flush = 0; ex_hold = 0;
        set_idle();
        #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_bubble_invalid();
        test_back_to_back();
        test_hold();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
